// File: rtl/gemm_pkg.sv
// Shared types for the GEMM command path: command kinds, per-engine tile
// parameters, scheduler FSM states and a small popcount helper.
package gemm_pkg;

  localparam int TILE_PARAMS_W = 59;

  typedef enum logic {
    CMD_TILE = 1'b0,
    CMD_WAIT = 1'b1
  } cmd_type_e;

  typedef struct packed {
    logic [15:0] left_addr;
    logic [15:0] right_addr;
    logic [7:0]  left_len;
    logic [7:0]  right_len;
    logic [7:0]  vec_len;
    logic        left_4b;
    logic        right_4b;
    logic        loop_left;
  } tile_params_t;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_BARRIER  = 2'd2
  } sched_state_e;

  // Number of set bits in a vector of up to 16 engines.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ce_slot_tracker.sv
// Per-engine bookkeeping: busy flag, held tile parameters, hang watchdog
// and its sticky timeout flag.
module ce_slot_tracker
  import gemm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         issue,
  input  tile_params_t issue_params,
  input  logic         done,
  input  logic         err_clear,
  output logic         busy,
  output tile_params_t params,
  output logic         timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_r;
  logic            wd_hit_s;

  // The watchdog reaches its limit on this edge.
  always_comb begin
    wd_hit_s = 1'b0;
    if (busy && !issue && (wd_r != WD_MAX)) begin
      wd_hit_s = ((wd_r + WD_W'(1)) == WD_MAX);
    end else begin
      wd_hit_s = 1'b0;
    end
  end

  // Busy is set by an issue and cleared only by the engine's done pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy <= 1'b0;
    end else if (issue) begin
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end
  end

  // Parameters stay stable from one issue to the next.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      params <= '0;
    end else if (issue) begin
      params <= issue_params;
    end
  end

  // Watchdog restarts on issue, counts busy cycles and saturates at the limit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wd_r <= '0;
    end else if (issue) begin
      wd_r <= '0;
    end else if (busy && (wd_r != WD_MAX)) begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  // Sticky timeout; a new hit takes priority over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      timeout <= 1'b0;
    end else if (wd_hit_s) begin
      timeout <= 1'b1;
    end else if (err_clear) begin
      timeout <= 1'b0;
    end
  end

endmodule

// File: rtl/ce_tile_scheduler.sv
// Schedules TILE and WAIT commands onto NUM_CE compute engines, with busy
// tracking, barrier waits, error flags and debug counters.
module ce_tile_scheduler
  import gemm_pkg::*;
#(
  parameter int NUM_CE         = 4,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int CEW            = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic                            i_cmd_type,
  input  logic [CEW-1:0]                  i_cmd_ce_id,
  input  logic [NUM_CE-1:0]               i_cmd_wait_mask,
  input  logic [15:0]                     i_cmd_left_addr,
  input  logic [15:0]                     i_cmd_right_addr,
  input  logic [7:0]                      i_cmd_left_ugd_len,
  input  logic [7:0]                      i_cmd_right_ugd_len,
  input  logic [7:0]                      i_cmd_vec_len,
  input  logic                            i_cmd_left_man_4b,
  input  logic                            i_cmd_right_man_4b,
  input  logic                            i_cmd_main_loop_over_left,
  output logic [NUM_CE-1:0]               o_ce_tile_en,
  output logic [NUM_CE*TILE_PARAMS_W-1:0] o_ce_params,
  input  logic [NUM_CE-1:0]               i_ce_tile_done,
  output logic                            o_barrier_done,
  output logic [NUM_CE-1:0]               o_ce_busy,
  output logic [NUM_CE-1:0]               o_ce_timeout,
  output logic                            o_err_spurious_done,
  input  logic                            i_err_clear,
  output logic [15:0]                     o_tiles_issued,
  output logic [15:0]                     o_tiles_done
);

  localparam logic [CEW:0] NUM_CE_W = (CEW+1)'(NUM_CE);

  sched_state_e  state_r, state_s;
  logic          ready_r, barrier_r, spurious_r;
  logic [NUM_CE-1:0] tile_en_r, issue_s, busy_s, timeout_s, done_ok_s, mask_r;
  logic [CEW-1:0] id_r;
  tile_params_t  cmd_params_r, in_params_s;
  tile_params_t  params_s [NUM_CE];
  logic          accept_s, barrier_s, bad_id_s, spurious_evt_s;
  logic [15:0]   issued_r, done_cnt_r;

  assign in_params_s = '{left_addr: i_cmd_left_addr, right_addr: i_cmd_right_addr,
                         left_len: i_cmd_left_ugd_len, right_len: i_cmd_right_ugd_len,
                         vec_len: i_cmd_vec_len, left_4b: i_cmd_left_man_4b,
                         right_4b: i_cmd_right_man_4b, loop_left: i_cmd_main_loop_over_left};

  // Next-state and one-cycle event decode for the command FSM.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    barrier_s = 1'b0;
    bad_id_s  = 1'b0;
    issue_s   = '0;
    case (state_r)
      ST_READY: begin
        if (i_cmd_valid && ready_r) begin
          accept_s = 1'b1;
          if (cmd_type_e'(i_cmd_type) == CMD_WAIT) begin
            state_s = ST_BARRIER;
          end else if ({1'b0, i_cmd_ce_id} < NUM_CE_W) begin
            state_s = ST_DISPATCH;
          end else begin
            bad_id_s = 1'b1;
          end
        end else begin
          state_s = ST_READY;
        end
      end
      ST_DISPATCH: begin
        if (!busy_s[id_r]) begin
          issue_s[id_r] = 1'b1;
          state_s       = ST_READY;
        end else begin
          state_s = ST_DISPATCH;
        end
      end
      ST_BARRIER: begin
        if ((busy_s & mask_r) == '0) begin
          barrier_s = 1'b1;
          state_s   = ST_READY;
        end else begin
          state_s = ST_BARRIER;
        end
      end
      default: state_s = ST_READY;
    endcase
  end

  assign done_ok_s      = i_ce_tile_done & busy_s;
  assign spurious_evt_s = (|(i_ce_tile_done & ~busy_s)) | bad_id_s;

  // FSM state plus registered ready, tile-enable and barrier pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= ST_READY;
      ready_r   <= 1'b0;
      tile_en_r <= '0;
      barrier_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ready_r   <= (state_s == ST_READY);
      tile_en_r <= issue_s;
      barrier_r <= barrier_s;
    end
  end

  // Capture the accepted command for the dispatch and barrier states.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      id_r         <= '0;
      mask_r       <= '0;
      cmd_params_r <= '0;
    end else if (accept_s) begin
      id_r         <= i_cmd_ce_id;
      mask_r       <= i_cmd_wait_mask;
      cmd_params_r <= in_params_s;
    end
  end

  // Wrapping debug counters; simultaneous dones add their popcount.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      issued_r   <= 16'd0;
      done_cnt_r <= 16'd0;
    end else begin
      issued_r   <= issued_r + ((|issue_s) ? 16'd1 : 16'd0);
      done_cnt_r <= done_cnt_r + {11'd0, popcount16(16'(done_ok_s))};
    end
  end

  // Sticky spurious-done / bad-target flag; a new event beats a clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      spurious_r <= 1'b0;
    end else if (spurious_evt_s) begin
      spurious_r <= 1'b1;
    end else if (i_err_clear) begin
      spurious_r <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CE; k++) begin : g_slot
    ce_slot_tracker #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_slot (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .issue        (issue_s[k]),
      .issue_params (cmd_params_r),
      .done         (i_ce_tile_done[k]),
      .err_clear    (i_err_clear),
      .busy         (busy_s[k]),
      .params       (params_s[k]),
      .timeout      (timeout_s[k])
    );
    assign o_ce_params[k*TILE_PARAMS_W +: TILE_PARAMS_W] = params_s[k];
  end

  assign o_cmd_ready         = ready_r;
  assign o_ce_tile_en        = tile_en_r;
  assign o_barrier_done      = barrier_r;
  assign o_ce_busy           = busy_s;
  assign o_ce_timeout        = timeout_s;
  assign o_err_spurious_done = spurious_r;
  assign o_tiles_issued      = issued_r;
  assign o_tiles_done        = done_cnt_r;

endmodule
